// File: rtl/keypoint_pkg.sv
// Shared widths, FSM encoding and keypoint record
// for the keypoint filter stage.
package keypoint_pkg;

  localparam int X_W   = 10;
  localparam int Y_W   = 10;
  localparam int DOG_W = 9;
  localparam int TH_W  = 10;
  localparam int CNT_W = 11;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [1:0]     octave;
    logic [1:0]     scale;
  } kp_rec_t;

endpackage

// File: rtl/kp_fifo.sv
// Synchronous FIFO for accepted keypoints.
// Head is read straight out of the storage registers.
module kp_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign rdata   = mem[rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      wp  <= wp + AW'(do_push);
      rp  <= rp + AW'(do_pop);
      cnt <= cnt + (AW+1)'(do_push)
                 - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

endmodule

// File: rtl/keypoint_filter.sv
// Keeps candidate extrema whose |DoG| beats the frame
// threshold, buffers them and publishes per-frame counts.
module keypoint_filter #(
  parameter int FIFO_DEPTH = 16,
  parameter int X_W        = 10,
  parameter int Y_W        = 10,
  parameter int DOG_W      = 9,
  parameter int TH_W       = 10,
  parameter int CNT_W      = 11,
  parameter int TH_INIT    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  input  logic                    frame_end,
  input  logic signed [TH_W-1:0]  filter_threshold,
  input  logic                    cand_valid,
  output logic                    cand_ready,
  input  logic [X_W-1:0]          cand_x,
  input  logic [Y_W-1:0]          cand_y,
  input  logic [1:0]              cand_octave,
  input  logic [1:0]              cand_scale,
  input  logic signed [DOG_W-1:0] cand_dog,
  output logic                    kp_valid,
  input  logic                    kp_ready,
  output logic [X_W-1:0]          kp_x,
  output logic [Y_W-1:0]          kp_y,
  output logic [1:0]              kp_octave,
  output logic [1:0]              kp_scale,
  output logic [CNT_W-1:0]        keypoint_num,
  output logic                    frame_done
);

  import keypoint_pkg::*;

  localparam int REC_W = X_W + Y_W + 4;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [0:0]            state;
  logic signed [TH_W-1:0] th_lat;
  logic signed [TH_W-1:0] th_use;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_inc;
  logic [DOG_W-1:0]      dog_abs;
  logic [TH_W:0]         mag;
  logic [TH_W:0]         th_x;
  logic                  xfer;
  logic                  live;
  logic                  accept;
  logic                  full;
  logic                  empty;
  logic [REC_W-1:0]      wrec;
  logic [REC_W-1:0]      hrec;

  assign cand_ready = !full;
  assign xfer       = cand_valid && cand_ready;
  assign live       = (state == ACTIVE) || frame_start;

  // In IDLE a same-cycle frame_start judges against the new threshold
  assign th_use  = (state == IDLE) ? filter_threshold : th_lat;
  assign dog_abs = cand_dog[DOG_W-1] ? (~cand_dog + 1'b1)
                                     : cand_dog;
  assign mag     = {{(TH_W+1-DOG_W){1'b0}}, dog_abs};
  assign th_x    = {th_use[TH_W-1], th_use};
  assign accept  = xfer && live &&
                   ($signed(mag) > $signed(th_x));
  assign cnt_inc = (cnt == CMAX) ? cnt
                                 : cnt + CNT_W'(accept);

  assign wrec = {cand_x, cand_y, cand_octave, cand_scale};
  assign {kp_x, kp_y, kp_octave, kp_scale} = hrec;
  assign kp_valid = !empty;

  kp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .wdata (wrec),
    .pop   (kp_ready),
    .rdata (hrec),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      th_lat       <= TH_W'(TH_INIT);
      keypoint_num <= '0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ACTIVE: begin
          if (frame_end) begin
            keypoint_num <= cnt_inc;
            frame_done   <= 1'b1;
            cnt          <= '0;
            state        <= frame_start ? ACTIVE : IDLE;
            if (frame_start) th_lat <= filter_threshold;
          end else if (frame_start) begin
            cnt    <= '0;
            th_lat <= filter_threshold;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          if (frame_start) begin
            th_lat <= filter_threshold;
            cnt    <= CNT_W'(accept);
            state  <= ACTIVE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypoint_filter.sv
// Directed bench for keypoint_filter: threshold rule,
// backpressure, saturation, frame abort and async reset.
module tb_keypoint_filter;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              frame_start = 1'b0;
  logic              frame_end = 1'b0;
  logic signed [9:0] filter_threshold = '0;
  logic              cand_valid = 1'b0;
  logic              cand_ready;
  logic [9:0]        cand_x = '0;
  logic [9:0]        cand_y = '0;
  logic [1:0]        cand_octave = '0;
  logic [1:0]        cand_scale = '0;
  logic signed [8:0] cand_dog = '0;
  logic              kp_valid;
  logic              kp_ready = 1'b1;
  logic [9:0]        kp_x;
  logic [9:0]        kp_y;
  logic [1:0]        kp_octave;
  logic [1:0]        kp_scale;
  logic [10:0]       keypoint_num;
  logic              frame_done;

  int n_chk = 0;
  int n_err = 0;
  int done_cnt = 0;
  int pops = 0;
  int exp_q [$];

  always #5 clk = ~clk;

  keypoint_filter dut (
    .clk              (clk),
    .rst              (rst),
    .frame_start      (frame_start),
    .frame_end        (frame_end),
    .filter_threshold (filter_threshold),
    .cand_valid       (cand_valid),
    .cand_ready       (cand_ready),
    .cand_x           (cand_x),
    .cand_y           (cand_y),
    .cand_octave      (cand_octave),
    .cand_scale       (cand_scale),
    .cand_dog         (cand_dog),
    .kp_valid         (kp_valid),
    .kp_ready         (kp_ready),
    .kp_x             (kp_x),
    .kp_y             (kp_y),
    .kp_octave        (kp_octave),
    .kp_scale         (kp_scale),
    .keypoint_num     (keypoint_num),
    .frame_done       (frame_done)
  );

  task automatic check(input string tag, input int obs,
                       input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int rec_of(input int x);
    logic [9:0] xx;
    xx = 10'(x);
    return {8'd0, xx, 10'(xx + 10'd100),
            2'(xx), 2'(xx >> 2)};
  endfunction

  // Pops happen at the next posedge; compare head in order
  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (!rst && kp_valid && kp_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        check("unexpected_pop", 1, 0);
      end else begin
        check("kp_head", {8'd0, kp_x, kp_y, kp_octave, kp_scale},
              exp_q.pop_front());
      end
    end
  end

  task automatic drive_cand(input int x, input int dog);
    cand_valid  = 1'b1;
    cand_x      = 10'(x);
    cand_y      = 10'(x + 100);
    cand_octave = 2'(x);
    cand_scale  = 2'(x >> 2);
    cand_dog    = 9'(dog);
  endtask

  task automatic send(input int x, input int dog,
                      input bit acc);
    bit sent;
    sent = 1'b0;
    if (acc) exp_q.push_back(rec_of(x));
    drive_cand(x, dog);
    for (int i = 0; i < 200 && !sent; i++) begin
      @(negedge clk);
      sent = cand_ready;
      @(posedge clk); #1;
    end
    cand_valid = 1'b0;
    if (!sent) check("send_timeout", 0, 1);
  endtask

  task automatic pulse_start(input int th);
    frame_start = 1'b1;
    filter_threshold = 10'(th);
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic pulse_end();
    frame_end = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++)
      @(posedge clk);
    #1;
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic end_and_check(input string tag, input int n);
    int d0;
    d0 = done_cnt;
    pulse_end();
    @(negedge clk);
    check({tag, "_done"}, int'(frame_done), 1);
    check({tag, "_num"}, int'(keypoint_num), n);
    @(negedge clk);
    check({tag, "_done_1cyc"}, done_cnt - d0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int dogs [6] = '{3, -3, 2, -2, 0, -256};
    bit accs [6] = '{1, 1, 0, 0, 0, 1};
    int d0;

    repeat (2) @(negedge clk);
    check("rst_kp_valid", int'(kp_valid), 0);
    check("rst_num", int'(keypoint_num), 0);
    check("rst_done", int'(frame_done), 0);
    check("rst_cand_ready", int'(cand_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // dog magnitude vs threshold 2, incl. most negative dog
    pulse_start(2);
    for (int i = 0; i < 6; i++) send(i + 1, dogs[i], accs[i]);
    end_and_check("t1", 3);
    drain();

    // threshold latched at frame_start; later change ignored
    pulse_start(-1);
    filter_threshold = 10'sd100;
    for (int i = 0; i < 5; i++) send(10 + i, 0, 1'b1);
    end_and_check("t2", 5);
    drain();

    // backpressure: 16 fill the FIFO then cand_ready drops
    kp_ready = 1'b0;
    pulse_start(2);
    for (int i = 0; i < 16; i++) send(20 + i, 10, 1'b1);
    @(negedge clk);
    check("full_cand_ready", int'(cand_ready), 0);
    check("full_kp_valid", int'(kp_valid), 1);
    check("full_head_x", int'(kp_x), 20);
    @(posedge clk); #1;
    pops = 0;
    kp_ready = 1'b1;
    for (int i = 16; i < 20; i++) send(20 + i, -10, 1'b1);
    end_and_check("t3", 20);
    drain();
    check("t3_pops", pops, 20);

    // running count saturates at 2047
    pulse_start(2);
    for (int i = 0; i < 2100; i++) send(i, 7, 1'b1);
    end_and_check("t4", 2047);
    drain();

    // abort: frame_start while ACTIVE discards the count
    pulse_start(2);
    for (int i = 0; i < 7; i++) send(50 + i, 20, 1'b1);
    d0 = done_cnt;
    pulse_start(2);
    @(negedge clk);
    @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_num_kept", int'(keypoint_num), 2047);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send(60 + i, 20, 1'b1);
    end_and_check("t5a", 4);

    // frame_end+frame_start together with an accept
    pulse_start(2);
    send(70, 30, 1'b1);
    send(71, -30, 1'b1);
    exp_q.push_back(rec_of(72));
    drive_cand(72, 40);
    frame_start = 1'b1;
    frame_end = 1'b1;
    @(negedge clk);
    check("se_cand_ready", int'(cand_ready), 1);
    @(posedge clk); #1;
    cand_valid = 1'b0;
    frame_start = 1'b0;
    frame_end = 1'b0;
    @(negedge clk);
    check("se_done", int'(frame_done), 1);
    check("se_num", int'(keypoint_num), 3);
    @(posedge clk); #1;
    send(73, 40, 1'b1);
    end_and_check("t5b", 1);
    drain();

    // async reset mid-frame with a non-empty FIFO
    kp_ready = 1'b0;
    pulse_start(2);
    for (int i = 0; i < 3; i++) send(80 + i, 40, 1'b1);
    @(negedge clk);
    check("pre_rst_kp_valid", int'(kp_valid), 1);
    #1;
    rst = 1'b1;
    #1;
    check("async_kp_valid", int'(kp_valid), 0);
    check("async_num", int'(keypoint_num), 0);
    check("async_done", int'(frame_done), 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    kp_ready = 1'b1;

    // IDLE: frame_end ignored, candidates discarded
    d0 = done_cnt;
    pulse_end();
    @(negedge clk);
    check("idle_end_done", done_cnt - d0, 0);
    check("idle_end_num", int'(keypoint_num), 0);
    @(posedge clk); #1;
    send(90, 100, 1'b0);
    @(negedge clk);
    check("idle_discard", int'(kp_valid), 0);
    @(posedge clk); #1;

    // IDLE frame_start with same-cycle transfer uses new threshold
    exp_q.push_back(rec_of(91));
    drive_cand(91, 0);
    pulse_start(-1);
    cand_valid = 1'b0;
    end_and_check("t6", 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
